// File: rtl/tex_arb_pkg.sv
// Shared constants and types for the texture ROM arbiter.
package tex_arb_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;

  localparam logic PORT_LCD   = 1'b0;
  localparam logic PORT_PROBE = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;
endpackage

// File: rtl/tex_arb_tag_pipe.sv
// Shift register carrying {valid, port} alongside each outstanding ROM read.
module tex_arb_tag_pipe
  import tex_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/tex_rom_arbiter.sv
// Two-port arbiter for the single-port texture ROM: LCD fetch has priority,
// probe port is protected by a starvation guard, responses routed by tag.
module tex_rom_arbiter
  import tex_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          lock0_i,
  input  logic [AW-1:0] addr0_i,
  output logic          gnt0_o,
  output logic          rvalid0_o,
  output logic [DW-1:0] rdata0_o,
  input  logic          req1_i,
  input  logic [AW-1:0] addr1_i,
  output logic          gnt1_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata1_o,
  output logic          rom_en_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic [DW-1:0] rom_data_i,
  output logic          starve_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          force1;
  tag_t          ret_tag;
  logic          hit0, hit1;
  logic [DW-1:0] rdata0_q, rdata1_q;

  // A locked port-0 burst outranks even the starvation force.
  always_comb begin
    gnt0_o   = 1'b0;
    gnt1_o   = 1'b0;
    starve_o = 1'b0;
    force1   = req1_i && (wait_cnt == CW'(MAX_WAIT));
    if (!rst) begin
      if (req0_i && lock0_i) begin
        gnt0_o = 1'b1;
      end else if (force1) begin
        gnt1_o   = 1'b1;
        starve_o = 1'b1;
      end else if (req0_i) begin
        gnt0_o = 1'b1;
      end else if (req1_i) begin
        gnt1_o = 1'b1;
      end
    end
  end

  assign rom_en_o   = gnt0_o | gnt1_o;
  assign rom_addr_o = gnt0_o ? addr0_i : (gnt1_o ? addr1_i : '0);

  always_ff @(posedge clk) begin
    if (rst || !req1_i || gnt1_o) wait_cnt <= '0;
    else if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  tex_arb_tag_pipe #(.DEPTH(ROM_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in ('{valid: rom_en_o, port: gnt1_o}),
    .tag_out(ret_tag)
  );

  // Data is forwarded the cycle it arrives and held afterwards.
  assign hit0 = !rst && ret_tag.valid && (ret_tag.port == PORT_LCD);
  assign hit1 = !rst && ret_tag.valid && (ret_tag.port == PORT_PROBE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (hit0) rdata0_q <= rom_data_i;
      if (hit1) rdata1_q <= rom_data_i;
    end
  end

  assign rvalid0_o = hit0;
  assign rvalid1_o = hit1;
  assign rdata0_o  = rst ? '0 : (hit0 ? rom_data_i : rdata0_q);
  assign rdata1_o  = rst ? '0 : (hit1 ? rom_data_i : rdata1_q);
endmodule
